// File: rtl/des_pkg.sv
// Shared DES constants, expansion table and round-control state type.
package des_pkg;

    localparam int unsigned HALF_W  = 32;
    localparam int unsigned KEY_W   = 48;
    localparam int unsigned BLOCK_W = 64;
    localparam int unsigned ROUNDS  = 16;
    localparam int unsigned RND_W   = 4;

    // E-box: output bit j (1 = MSB) takes input bit E_TABLE[j-1] (1 = MSB).
    localparam int unsigned E_TABLE [KEY_W] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/des_expand.sv
// Combinational 32-to-48 DES expansion (E-box); shared with the decrypt path.
module des_expand
    import des_pkg::*;
(
    input  logic [HALF_W-1:0] r_i,
    output logic [KEY_W-1:0]  e_o
);

    // Pure wiring: each output bit is a copy of one input bit.
    for (genvar j = 1; j <= int'(KEY_W); j++) begin : g_ebit
        assign e_o[KEY_W-j] = r_i[HALF_W-E_TABLE[j-1]];
    end

endmodule

// File: rtl/des_round_engine.sv
// Iterative DES Feistel round engine: one round per clock, 16 rounds per block.
module des_round_engine
    import des_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [BLOCK_W-1:0] data_in,
    input  logic [KEY_W-1:0]   subkey,
    input  logic [HALF_W-1:0]  f_in,
    output logic [KEY_W-1:0]   sbox_in,
    output logic [RND_W-1:0]   round_idx,
    output logic               busy,
    output logic               done,
    output logic [BLOCK_W-1:0] data_out
);

    state_e              state_q, state_d;
    logic [HALF_W-1:0]   l_q, l_d;
    logic [HALF_W-1:0]   r_q, r_d;
    logic [RND_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;
    logic [BLOCK_W-1:0]  dout_q, dout_d;
    logic [KEY_W-1:0]    e_r;

    des_expand u_expand (
        .r_i (r_q),
        .e_o (e_r)
    );

    // State register; reset aborts any block in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            l_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
        end
    end

    // Round control: load when idle, otherwise run one Feistel round per cycle.
    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        dout_d  = dout_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    l_d     = data_in[BLOCK_W-1:HALF_W];
                    r_d     = data_in[HALF_W-1:0];
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                l_d   = r_q;
                r_d   = l_q ^ f_in;
                cnt_d = cnt_q + RND_W'(1);
                if (cnt_q == RND_W'(ROUNDS - 1)) begin
                    // Last round: output is {R16, L16}, undoing the final swap.
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    dout_d  = {l_q ^ f_in, r_q};
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign sbox_in   = e_r ^ subkey;
    assign round_idx = cnt_q;
    assign busy      = (state_q == ST_BUSY);
    assign done      = done_q;
    assign data_out  = dout_q;

endmodule

// File: tb/tb_des_round_engine.sv
// Self-checking bench for des_round_engine with a scoreboard of expected blocks.
module tb_des_round_engine;

    localparam int E_TAB [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] data_in = '0;
    logic [1:0]  f_mode = 2'd0;
    logic        k_mode = 1'b0;
    logic [47:0] k_const = '0;
    logic [47:0] subkey;
    logic [31:0] f_in;
    logic [47:0] sbox_in;
    logic [3:0]  round_idx;
    logic        busy;
    logic        done;
    logic [63:0] data_out;

    logic [31:0] exp_in = '0;
    logic [47:0] exp_out;

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  fm;
        logic        km;
        logic [47:0] kc;
        logic [63:0] res;
    } vec_t;

    typedef struct {
        logic [31:0] in;
        logic [47:0] out;
    } evec_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    des_round_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .data_in   (data_in),
        .subkey    (subkey),
        .f_in      (f_in),
        .sbox_in   (sbox_in),
        .round_idx (round_idx),
        .busy      (busy),
        .done      (done),
        .data_out  (data_out)
    );

    des_expand u_exp (
        .r_i (exp_in),
        .e_o (exp_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [47:0] tb_expand(logic [31:0] r);
        logic [47:0] o;
        o = '0;
        for (int j = 1; j <= 48; j++) o[48-j] = r[32-E_TAB[j-1]];
        return o;
    endfunction

    function automatic logic [47:0] key_of(logic km, logic [47:0] kc, logic [3:0] k);
        return km ? (48'h0F1E2D3C4B5A ^ {12{k}}) : kc;
    endfunction

    function automatic logic [31:0] f_of(logic [47:0] s, logic [1:0] m);
        case (m)
            2'd0:    return 32'h0;
            2'd1:    return 32'hFFFFFFFF;
            default: return s[47:16] ^ {s[15:0], s[47:32]};
        endcase
    endfunction

    function automatic logic [63:0] model(logic [63:0] d, logic [1:0] fm, logic km, logic [47:0] kc);
        logic [31:0] l, r, t;
        l = d[63:32];
        r = d[31:0];
        for (int k = 0; k < 16; k++) begin
            t = l ^ f_of(tb_expand(r) ^ key_of(km, kc, 4'(k)), fm);
            l = r;
            r = t;
        end
        return {r, l};
    endfunction

    // Key schedule and f-function stand-ins driven from the DUT's round state.
    always_comb subkey = key_of(k_mode, k_const, round_idx);
    always_comb f_in   = f_of(sbox_in, f_mode);

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Scoreboard: every done must match the oldest outstanding block and its cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
            end else begin
                e = sb.pop_front();
                chk("done_data", data_out, e.data);
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(logic [63:0] d, logic [63:0] res);
        data_in = d;
        start   = 1'b1;
        sb.push_back('{res, cyc + 17});
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_drain(int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got %0d pending blocks expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vecs[4];
        evec_t evs[4];
        logic [63:0] d1, d2;
        logic [31:0] r1;
        int n;

        evs[0] = '{32'h00000001, 48'h800000000002};
        evs[1] = '{32'h80000000, 48'h400000000001};
        evs[2] = '{32'hFFFFFFFF, 48'hFFFFFFFFFFFF};
        evs[3] = '{32'h00000000, 48'h000000000000};

        vecs[0] = '{64'h0123456789ABCDEF, 2'd0, 1'b0, 48'h0, 64'h89ABCDEF01234567};
        vecs[1] = '{64'h0123456789ABCDEF, 2'd1, 1'b0, 48'h0, 64'h89ABCDEF01234567};
        vecs[2] = '{64'h0123456789ABCDEF, 2'd2, 1'b1, 48'h0, 64'h0};
        vecs[3] = '{64'hDEADBEEFCAFEF00D, 2'd2, 1'b0, 48'h5A5A3C3C0F0F, 64'h0};
        vecs[2].res = model(vecs[2].data, vecs[2].fm, vecs[2].km, vecs[2].kc);
        vecs[3].res = model(vecs[3].data, vecs[3].fm, vecs[3].km, vecs[3].kc);

        // Reset state
        k_const = 48'h123456789ABC;
        #12;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_data_out", data_out, 64'h0);
        chk("rst_round_idx", 64'(round_idx), 64'(0));
        chk("rst_sbox_in", 64'(sbox_in), 64'(48'h123456789ABC));
        tick();
        rst_n = 1'b1;
        tick();

        // Expansion vectors
        for (int i = 0; i < 4; i++) begin
            exp_in = evs[i].in;
            #1;
            chk($sformatf("expand_%0d", i), 64'(exp_out), 64'(evs[i].out));
        end

        // sbox_in after load with R = 1 and subkey = 3
        f_mode = 2'd0; k_mode = 1'b0; k_const = 48'h000000000003;
        issue(64'h0000000000000001, model(64'h1, 2'd0, 1'b0, 48'h3));
        chk("load_sbox_in", 64'(sbox_in), 64'(48'h800000000001));
        wait_drain(40);

        // Table-driven full blocks
        for (int i = 0; i < 4; i++) begin
            f_mode  = vecs[i].fm;
            k_mode  = vecs[i].km;
            k_const = vecs[i].kc;
            issue(vecs[i].data, vecs[i].res);
            chk($sformatf("v%0d_busy", i), 64'(busy), 64'(1));
            chk($sformatf("v%0d_round0", i), 64'(round_idx), 64'(0));
            chk($sformatf("v%0d_sbox0", i), 64'(sbox_in),
                64'(tb_expand(vecs[i].data[31:0]) ^ key_of(vecs[i].km, vecs[i].kc, 4'd0)));
            r1 = vecs[i].data[63:32] ^ f_of(tb_expand(vecs[i].data[31:0])
                 ^ key_of(vecs[i].km, vecs[i].kc, 4'd0), vecs[i].fm);
            tick();
            chk($sformatf("v%0d_round1", i), 64'(round_idx), 64'(1));
            chk($sformatf("v%0d_sbox1", i), 64'(sbox_in),
                64'(tb_expand(r1) ^ key_of(vecs[i].km, vecs[i].kc, 4'd1)));
            wait_drain(40);
            tick();
            chk($sformatf("v%0d_idle", i), 64'(busy), 64'(0));
            chk($sformatf("v%0d_held", i), data_out, vecs[i].res);
        end

        // start while busy at round 5 is ignored
        f_mode = 2'd2; k_mode = 1'b1;
        d1 = 64'h0F1E2D3C4B5A6978;
        d2 = 64'hFFFF0000AAAA5555;
        issue(d1, model(d1, 2'd2, 1'b1, k_const));
        repeat (5) tick();
        chk("mid_round5", 64'(round_idx), 64'(5));
        data_in = d2;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("mid_round6", 64'(round_idx), 64'(6));
        wait_drain(40);
        chk("mid_no_reload", 64'(busy), 64'(0));

        // start during the done cycle loads the next block
        issue(d1, model(d1, 2'd2, 1'b1, k_const));
        n = 0;
        while (!done && n < 30) begin
            tick();
            n++;
        end
        chk("b2b_done_seen", 64'(done), 64'(1));
        data_in = d2;
        start = 1'b1;
        sb.push_back('{model(d2, 2'd2, 1'b1, k_const), cyc + 17});
        tick();
        start = 1'b0;
        chk("b2b_busy", 64'(busy), 64'(1));
        chk("b2b_round0", 64'(round_idx), 64'(0));
        wait_drain(40);

        // Asynchronous reset at round 8
        issue(d1, model(d1, 2'd2, 1'b1, k_const));
        repeat (8) tick();
        chk("rst8_round", 64'(round_idx), 64'(8));
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("rst8_busy", 64'(busy), 64'(0));
        chk("rst8_done", 64'(done), 64'(0));
        chk("rst8_data_out", data_out, 64'h0);
        chk("rst8_round_idx", 64'(round_idx), 64'(0));
        tick();
        rst_n = 1'b1;
        repeat (25) tick();
        chk("rst8_still_idle", 64'(busy), 64'(0));
        chk("rst8_data_kept0", data_out, 64'h0);

        // Recovery after reset
        issue(d2, model(d2, 2'd2, 1'b1, k_const));
        wait_drain(40);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
